// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port among NUM_REQ
// write-back producers and tracks outstanding writes in a 64-entry scoreboard
// (index {isfloat, rd}) that drives the decode hazard.
// Optional macro RR_ARB_EN: round-robin arbitration; undefined -> fixed priority.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [5*NUM_REQ-1:0]    req_rd,
  input  logic [NUM_REQ-1:0]      req_isfloat,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    wb_en,
  output logic [4:0]              wb_rd,
  output logic                    wb_isfloat,
  output logic [31:0]             wb_data,
  input  logic                    issue_valid,
  input  logic [4:0]              issue_rd,
  input  logic                    issue_isfloat,
  input  logic [4:0]              chk_rs1,
  input  logic [4:0]              chk_rs2,
  input  logic [4:0]              chk_rd,
  input  logic                    chk_rs1_f,
  input  logic                    chk_rs2_f,
  input  logic                    chk_rd_f,
  input  logic                    chk_rd_en,
  output logic                    hazard,
  output logic [6:0]              pending_cnt
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic          gnt;
  logic [IW-1:0] gidx;
  int            sel_j;
  logic [4:0]    g_rd;
  logic          g_f;
  logic [31:0]   g_data;

  logic          wb_en_q, wb_en_d, wb_f_q, wb_f_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [63:0]   sb_q, sb_d;
  logic [6:0]    cnt_q, cnt_d;
  logic          set_en, clr_en, inc, dec;
  logic [5:0]    set_idx, clr_idx, rs1_idx, rs2_idx, rd_idx;
  logic          rs1_hz, rs2_hz, rd_hz;

`ifdef RR_ARB_EN
  logic [IW-1:0] ptr_q, ptr_d;
`endif

  // Grant search: first valid requester starting at the pointer (or at 0)
  always_comb begin
    gnt       = 1'b0;
    gidx      = '0;
    req_ready = '0;
    sel_j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef RR_ARB_EN
      sel_j = int'(ptr_q) + k;
      if (sel_j >= NUM_REQ) sel_j = sel_j - NUM_REQ;
`else
      sel_j = k;
`endif
      if (!gnt && req_valid[sel_j]) begin
        gnt  = 1'b1;
        gidx = IW'(sel_j);
      end
    end
    if (rst) gnt = 1'b0;
    if (gnt) req_ready[gidx] = 1'b1;
  end

  assign g_rd   = req_rd[5*int'(gidx) +: 5];
  assign g_f    = req_isfloat[gidx];
  assign g_data = req_data[32*int'(gidx) +: 32];

`ifdef RR_ARB_EN
  // Pointer moves to the requester after the winner, only when a grant happens
  assign ptr_d = !gnt ? ptr_q :
                 (gidx == IW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
`endif

  // Write-port next state: x0 writes take the slot but never enable the port
  always_comb begin
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_f_d    = wb_f_q;
    wb_data_d = wb_data_q;
    if (gnt) begin
      wb_en_d   = g_f || (g_rd != 5'd0);
      wb_rd_d   = g_rd;
      wb_f_d    = g_f;
      wb_data_d = g_data;
    end
  end

  assign set_idx = {issue_isfloat, issue_rd};
  assign set_en  = issue_valid && (issue_isfloat || (issue_rd != 5'd0));
  assign clr_idx = {wb_f_q, wb_rd_q};
  assign clr_en  = wb_en_q;

  // Scoreboard update; set wins over a same-index clear, count follows popcount
  always_comb begin
    sb_d = sb_q;
    if (clr_en) sb_d[clr_idx] = 1'b0;
    if (set_en) sb_d[set_idx] = 1'b1;
    inc   = set_en && !sb_q[set_idx];
    dec   = clr_en && sb_q[clr_idx] && !(set_en && (set_idx == clr_idx));
    cnt_d = cnt_q;
    if (inc && !dec && (cnt_q != 7'd64))      cnt_d = cnt_q + 7'd1;
    else if (dec && !inc && (cnt_q != 7'd0))  cnt_d = cnt_q - 7'd1;
  end

  assign rs1_idx = {chk_rs1_f, chk_rs1};
  assign rs2_idx = {chk_rs2_f, chk_rs2};
  assign rd_idx  = {chk_rd_f, chk_rd};
  // An entry being retired this cycle is already forwarded by the register file
  assign rs1_hz = (chk_rs1_f || (chk_rs1 != 5'd0)) && sb_q[rs1_idx] &&
                  !(clr_en && (clr_idx == rs1_idx));
  assign rs2_hz = (chk_rs2_f || (chk_rs2 != 5'd0)) && sb_q[rs2_idx] &&
                  !(clr_en && (clr_idx == rs2_idx));
  assign rd_hz  = chk_rd_en && (chk_rd_f || (chk_rd != 5'd0)) && sb_q[rd_idx] &&
                  !(clr_en && (clr_idx == rd_idx));
  assign hazard = rs1_hz || rs2_hz || rd_hz;

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_f_q    <= 1'b0;
      wb_data_q <= '0;
      sb_q      <= '0;
      cnt_q     <= '0;
`ifdef RR_ARB_EN
      ptr_q     <= '0;
`endif
    end else begin
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_f_q    <= wb_f_d;
      wb_data_q <= wb_data_d;
      sb_q      <= sb_d;
      cnt_q     <= cnt_d;
`ifdef RR_ARB_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign wb_en       = wb_en_q;
  assign wb_rd       = wb_rd_q;
  assign wb_isfloat  = wb_f_q;
  assign wb_data     = wb_data_q;
  assign pending_cnt = cnt_q;

endmodule
